// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch definitions (instruction length, reset vector, FSM states).
`ifndef FETCH_CTRL_DEFS
`define FETCH_CTRL_DEFS
`define INST_LENTH 4
`define RESET_VEC 32'h8000_0000
`endif

package fetch_ctrl_pkg;
    localparam int unsigned INST_LENTH_P = `INST_LENTH;
    localparam logic [31:0] RESET_VEC_P = `RESET_VEC;

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, FLUSH} fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt: branch, taken-branch and redirect event counters (32-bit, wrapping).
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_br,
    input  logic        is_br_taken,
    input  logic        redir,
    output logic [31:0] br_cnt,
    output logic [31:0] taken_cnt,
    output logic [31:0] redir_cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (is_br) br_cnt <= br_cnt + 32'd1;
            if (is_br && is_br_taken) taken_cnt <= taken_cnt + 32'd1;
            if (redir) redir_cnt <= redir_cnt + 32'd1;
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and single-outstanding instruction fetch sequencer with redirect squash.
// Perf counters are built only when FETCH_PERF_EN is defined; otherwise they read 0.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_P,
    parameter int unsigned INST_LEN  = INST_LENTH_P
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        id_ready,
    input  logic        is_br,
    input  logic        is_br_taken,
    output logic [31:0] perf_br_cnt,
    output logic [31:0] perf_taken_cnt,
    output logic [31:0] perf_redir_cnt
);
    fetch_state_t state, next;
    logic [31:0]  pc, fetch_pc, target;
    logic         redir, issue, land;

    // Redirects are ignored in IDLE; trap beats execute redirect.
    assign redir  = (trap_valid || redirect_valid) && state != IDLE;
    assign target = align_word(trap_valid ? trap_pc : redirect_pc);
    assign imem_addr = pc;
    assign issue  = imem_req && imem_gnt;
    assign land   = state == WAIT && imem_rvalid && !redir;

    always_comb begin
        imem_req = 1'b0;
        next = state;
        case (state)
            IDLE: next = FETCH;
            FETCH: begin
                imem_req = !inst_valid || id_ready;
                next = (imem_req && imem_gnt) ? (redir ? FLUSH : WAIT) : FETCH;
            end
            WAIT:  next = imem_rvalid ? FETCH : (redir ? FLUSH : WAIT);
            FLUSH: next = imem_rvalid ? FETCH : FLUSH;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_VEC;
            fetch_pc <= '0;
        end else begin
            state <= next;
            if (redir) pc <= target;
            else if (issue) pc <= pc + 32'(INST_LEN);
            if (issue) fetch_pc <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else if (redir) begin
            inst_valid <= 1'b0;
        end else if (land) begin
            inst_valid <= 1'b1;
            inst       <= imem_rdata;
            inst_pc    <= fetch_pc;
        end else if (id_ready) begin
            inst_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .is_br       (is_br),
        .is_br_taken (is_br_taken),
        .redir       (redir),
        .br_cnt      (perf_br_cnt),
        .taken_cnt   (perf_taken_cnt),
        .redir_cnt   (perf_redir_cnt)
    );
`else
    logic perf_unused;
    assign perf_unused    = ^{is_br, is_br_taken, redir};
    assign perf_br_cnt    = '0;
    assign perf_taken_cnt = '0;
    assign perf_redir_cnt = '0;
`endif
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Owns the architectural PC register and sequences instruction fetch against a single-port instruction memory, one request outstanding at a time.
Chooses each next fetch address from three sources: sequential PC+4, the execute-stage redirect (the dnpc of a taken branch or jump), and the CSR trap/mret target.
Delivers fetched instructions to decode through a one-entry valid/ready output buffer.
Squashes wrong-path responses after a redirect.

Parameters:
RESET_VEC, 32'h8000_0000, PC loaded at reset.
INST_LEN, 4, byte increment for a sequential fetch; must equal the shared `INST_LENTH.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address, word-aligned.
imem_gnt  in  1  request accepted this cycle.
imem_rvalid  in  1  read data valid; earliest the cycle after gnt.
imem_rdata  in  32  instruction word.
redirect_valid  in  1  execute-stage PC redirect.
redirect_pc  in  32  redirect target.
trap_valid  in  1  trap entry or mret.
trap_pc  in  32  mtvec or epc.
inst_valid  out  1  decode output valid.
inst  out  32  instruction.
inst_pc  out  32  PC of inst.
id_ready  in  1  decode accepts.
is_br  in  1  retiring instruction is a conditional branch; perf only.
is_br_taken  in  1  that branch was taken; perf only.
perf_br_cnt  out  32  perf counter.
perf_taken_cnt  out  32  perf counter.
perf_redir_cnt  out  32  perf counter.

Behaviour:
- Reset (async, active-high):
  - pc = RESET_VEC, state = IDLE.
  - imem_req = 0, inst_valid = 0, inst = 0, inst_pc = 0, all perf counters = 0.
- State IDLE:
  - Unconditionally moves to FETCH on the first clock after rst deasserts.
- State FETCH:
  - imem_req = 1 only when the output buffer is empty or is consumed this cycle (inst_valid && id_ready); otherwise imem_req = 0.
  - imem_addr = pc whenever imem_req = 1.
  - On req && gnt: fetch_pc <= pc, pc <= pc + INST_LEN, go to WAIT.
- State WAIT:
  - imem_req = 0.
  - On rvalid: inst <= rdata, inst_pc <= fetch_pc, inst_valid <= 1, go to FETCH.
  - The buffer is guaranteed free because of the FETCH issue rule.
- Output buffer:
  - inst_valid clears on id_ready when no new data is loaded the same cycle.
  - inst and inst_pc stay stable while inst_valid && !id_ready.
- Redirect priority:
  - trap_valid beats redirect_valid.
  - Target bits [1:0] are forced to 0.
- Redirect effects, in any state except IDLE:
  - pc <= target, inst_valid <= 0 (buffered instruction squashed), perf_redir_cnt increments.
- Redirect next state:
  - FETCH without gnt: stay in FETCH. The un-granted request is retracted and imem_addr = target from the next cycle.
  - FETCH with gnt in the same cycle: go to FLUSH.
  - WAIT without rvalid: go to FLUSH.
  - WAIT with rvalid in the same cycle: the response is dropped, go to FETCH.
- State FLUSH:
  - imem_req = 0, inst_valid stays 0.
  - On rvalid: discard the data, go to FETCH.
  - A further redirect in FLUSH only updates pc and stays in FLUSH; if rvalid arrives in that same cycle, go to FETCH.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - A response already in flight is the memory's responsibility; fetch_ctrl ignores rvalid while in IDLE.
- Arithmetic: pc + INST_LEN is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 with no error.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined:
  - perf_br_cnt increments when is_br = 1.
  - perf_taken_cnt increments when is_br && is_br_taken.
  - perf_redir_cnt increments as stated under Behaviour.
  - All three counters are 32-bit, wrap, and reset to 0.
- Undefined:
  - All three perf outputs are tied to 0, with no flops inferred.
  - is_br and is_br_taken are ignored.
  - The port list is identical in both builds.

Decomposition:
- Shared defs file:
  - `INST_LENTH (reused as the INST_LEN default).
  - fetch_state_t enum {IDLE, FETCH, WAIT, FLUSH}, 2 bits.
  - `RESET_VEC constant.
- One natural sub-module: fetch_perf_cnt. It holds the three counters and is instantiated only under FETCH_PERF_EN.

Test Plan:
- Reset release, gnt always 1, rvalid 1 cycle after gnt, id_ready = 1 -> fetches at 0x8000_0000, 0x8000_0004, 0x8000_0008; inst_pc matches each address.
- id_ready = 0 for 5 cycles with inst_valid = 1 -> imem_req stays 0; inst/inst_pc stable; resumes on id_ready.
- redirect_valid with redirect_pc = 0x8000_0100 while in WAIT -> FLUSH; stale response dropped; next imem_addr = 0x8000_0100; no inst_valid for the stale word.
- trap_valid (trap_pc = 0x8000_0040) and redirect_valid (0x8000_0200) in the same cycle -> next fetch at 0x8000_0040.
- Redirect coincident with rvalid in WAIT; also redirect_pc = 0x8000_0102 -> response dropped, no FLUSH; fetch at 0x8000_0100.
- FETCH_PERF_EN: 3 is_br pulses, 2 with is_br_taken, 1 redirect -> perf_br_cnt = 3, perf_taken_cnt = 2, perf_redir_cnt = 1; rst mid-run zeros all three.
